// File: rtl/falling_edge_pulse_gen_pkg.sv
// Shared types and constants for the falling-edge pulse train generator.
//   state_e     : controller state (idle, low phase, high phase)
//   DefCntW     : default width of the low/high phase length fields
//   DefRepW     : default width of the pulse-count field
//   OIdleLevel  : level driven on O whenever no low phase is in progress
package falling_edge_pulse_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLow,
    StHigh
  } state_e;

  localparam int unsigned DefCntW = 8;
  localparam int unsigned DefRepW = 4;

  localparam logic OIdleLevel = 1'b1;

endpackage

// File: rtl/falling_edge_pulse_gen_phase_timer.sv
// Loadable down-counter shared by the low and high phases.
//   clk_i      : clock, posedge
//   rst_ni     : synchronous active-low reset, clears the count
//   load_i     : load load_val_i (takes priority over en_i)
//   load_val_i : value to load (phase length minus one)
//   en_i       : decrement by one; holds at zero, never wraps
//   zero_o     : count is zero, i.e. the current cycle is the last of the phase
module falling_edge_pulse_gen_phase_timer #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            en_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/falling_edge_pulse_gen.sv
// Programmable active-low pulse train generator.
//   clk         : clock, all logic on posedge
//   reset       : synchronous active-low reset
//   start       : begin a train (sampled only while idle)
//   low_len     : cycles O is low per pulse (0 treated as 1), latched on start
//   high_len    : cycles O is high after each low phase (0 treated as 1), latched on start
//   num_pulses  : pulses per train, latched on start; 0 just returns done
//   abort       : end the train immediately while busy, without done
//   O           : registered waveform, idle high
//   fall_strobe : registered, high in the first low cycle of each pulse
//   busy        : train in progress
//   done        : one-cycle pulse on normal completion
module falling_edge_pulse_gen
  import falling_edge_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned REP_W = DefRepW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] high_len,
  input  logic [REP_W-1:0] num_pulses,
  input  logic             abort,
  output logic             O,
  output logic             fall_strobe,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic             o_q, o_d;
  logic             fs_q, fs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [REP_W-1:0] num_q, num_d;
  logic [REP_W-1:0] pcnt_q, pcnt_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_zero;

  logic [CNT_W-1:0] low_eff;
  logic [CNT_W-1:0] high_eff;

  // Zero-length phases are stretched to one cycle so every pulse has a real edge.
  assign low_eff  = (low_len == '0) ? CNT_W'(1) : low_len;
  assign high_eff = (high_len == '0) ? CNT_W'(1) : high_len;

  falling_edge_pulse_gen_phase_timer #(
    .CntW (CNT_W)
  ) u_phase_timer (
    .clk_i      (clk),
    .rst_ni     (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    o_d      = o_q;
    fs_d     = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    low_d    = low_q;
    high_d   = high_q;
    num_d    = num_q;
    pcnt_d   = pcnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;

    case (state_q)
      StIdle: begin
        o_d    = OIdleLevel;
        busy_d = 1'b0;
        if (start) begin
          if (num_pulses == '0) begin
            done_d = 1'b1;
          end else begin
            low_d    = low_eff;
            high_d   = high_eff;
            num_d    = num_pulses;
            pcnt_d   = REP_W'(1);
            state_d  = StLow;
            o_d      = ~OIdleLevel;
            fs_d     = 1'b1;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = low_eff - CNT_W'(1);
          end
        end
      end

      StLow: begin
        if (abort) begin
          state_d = StIdle;
          o_d     = OIdleLevel;
          busy_d  = 1'b0;
        end else if (tmr_zero) begin
          state_d  = StHigh;
          o_d      = OIdleLevel;
          tmr_load = 1'b1;
          tmr_val  = high_q - CNT_W'(1);
        end else begin
          tmr_en = 1'b1;
        end
      end

      StHigh: begin
        if (abort) begin
          state_d = StIdle;
          o_d     = OIdleLevel;
          busy_d  = 1'b0;
        end else if (tmr_zero) begin
          if (pcnt_q == num_q) begin
            // Last high phase finished: train complete.
            state_d = StIdle;
            o_d     = OIdleLevel;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = StLow;
            o_d      = ~OIdleLevel;
            fs_d     = 1'b1;
            pcnt_d   = pcnt_q + REP_W'(1);
            tmr_load = 1'b1;
            tmr_val  = low_q - CNT_W'(1);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        o_d     = OIdleLevel;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      o_q     <= OIdleLevel;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      low_q   <= '0;
      high_q  <= '0;
      num_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      low_q   <= low_d;
      high_q  <= high_d;
      num_q   <= num_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign O           = o_q;
  assign fall_strobe = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_falling_edge_pulse_gen.sv
module tb_falling_edge_pulse_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] low_len = '0;
  logic [7:0] high_len = '0;
  logic [3:0] num_pulses = '0;
  logic       abort = 1'b0;
  logic       O;
  logic       fall_strobe;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  falling_edge_pulse_gen #(
    .CNT_W (8),
    .REP_W (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .low_len     (low_len),
    .high_len    (high_len),
    .num_pulses  (num_pulses),
    .abort       (abort),
    .O           (O),
    .fall_strobe (fall_strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Attached falling-edge detector: Q <= O; out = Q & ~O.
  logic det_q = 1'b1;
  always @(posedge clk) det_q <= O;

  // Reference model: a train is a start edge k plus (L, H, N); the waveform at edge t
  // follows from the offset t-k by plain arithmetic.
  int   m_t = 0;
  int   m_k = 0;
  int   m_l = 1;
  int   m_h = 1;
  int   m_n = 0;
  logic m_act = 1'b0;
  logic m_o = 1'b1;
  logic m_fs = 1'b0;
  logic m_busy = 1'b0;
  logic m_done = 1'b0;

  always @(posedge clk) begin : ref_model
    int per;
    int off;
    per = m_l + m_h;
    off = m_t - m_k;
    m_t <= m_t + 1;
    if (!reset) begin
      m_act <= 1'b0; m_o <= 1'b1; m_fs <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_act) begin
      if (abort) begin
        m_act <= 1'b0; m_o <= 1'b1; m_fs <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      end else if (off == m_n * per) begin
        m_act <= 1'b0; m_o <= 1'b1; m_fs <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1;
      end else begin
        m_o    <= ((off % per) >= m_l);
        m_fs   <= ((off % per) == 0);
        m_busy <= 1'b1;
        m_done <= 1'b0;
      end
    end else begin
      m_o <= 1'b1; m_fs <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
      if (start) begin
        if (num_pulses == 0) begin
          m_done <= 1'b1;
        end else begin
          m_act  <= 1'b1;
          m_k    <= m_t;
          m_l    <= (low_len == 0) ? 1 : int'(low_len);
          m_h    <= (high_len == 0) ? 1 : int'(high_len);
          m_n    <= int'(num_pulses);
          m_o    <= 1'b0;
          m_fs   <= 1'b1;
          m_busy <= 1'b1;
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({O, fall_strobe, busy, done} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_state got=%b want=1000", {O, fall_strobe, busy, done});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int falls = 0;
    int dones = 0;
    int done_off = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      start = (i == 0);
      low_len = 8'd3; high_len = 8'd2; num_pulses = 4'd2;
      if (i > 0) begin
        low_len = 8'($urandom); high_len = 8'($urandom); num_pulses = 4'($urandom);
      end
      @(posedge clk); #1;
      checks++;
      if ({O, fall_strobe, busy, done} !== {m_o, m_fs, m_busy, m_done}) begin
        failures++;
        $display("FAIL basic i=%0d got=%b want=%b", i, {O, fall_strobe, busy, done},
                 {m_o, m_fs, m_busy, m_done});
      end
      checks++;
      if (fall_strobe !== (det_q & ~O)) begin
        failures++;
        $display("FAIL basic_edge_det i=%0d got=%b want=%b", i, fall_strobe, det_q & ~O);
      end
      if (fall_strobe === 1'b1) falls++;
      if (done === 1'b1) begin
        dones++;
        done_off = i;
      end
    end
    start = 1'b0;
    checks++;
    if (falls != 2 || dones != 1 || done_off != 10) begin
      failures++;
      $display("FAIL basic_summary falls=%0d dones=%0d done_off=%0d want 2 1 10",
               falls, dones, done_off);
    end
  endtask

  task automatic test_zero_len();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = (i == 0);
      low_len = '0; high_len = '0; num_pulses = 4'd3;
      @(posedge clk); #1;
      checks++;
      if ({O, fall_strobe, busy, done} !== {m_o, m_fs, m_busy, m_done}) begin
        failures++;
        $display("FAIL zero_len i=%0d got=%b want=%b", i, {O, fall_strobe, busy, done},
                 {m_o, m_fs, m_busy, m_done});
      end
      checks++;
      if (fall_strobe !== (det_q & ~O)) begin
        failures++;
        $display("FAIL zero_len_edge_det i=%0d got=%b want=%b", i, fall_strobe, det_q & ~O);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_zero_count();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = (i == 0);
      low_len = 8'd4; high_len = 8'd4; num_pulses = '0;
      @(posedge clk); #1;
      checks++;
      if ({O, fall_strobe, busy, done} !== {m_o, m_fs, m_busy, m_done}) begin
        failures++;
        $display("FAIL zero_count i=%0d got=%b want=%b", i, {O, fall_strobe, busy, done},
                 {m_o, m_fs, m_busy, m_done});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      // Start at 0, abort in the 3rd low cycle, restart (with abort also high) at 5.
      start = (i == 0) || (i == 5);
      abort = (i == 3) || (i == 5);
      low_len = 8'd5; high_len = 8'd5; num_pulses = 4'd4;
      if (i == 5) begin
        low_len = 8'd1; high_len = 8'd2; num_pulses = 4'd2;
      end
      @(posedge clk); #1;
      checks++;
      if ({O, fall_strobe, busy, done} !== {m_o, m_fs, m_busy, m_done}) begin
        failures++;
        $display("FAIL abort i=%0d got=%b want=%b", i, {O, fall_strobe, busy, done},
                 {m_o, m_fs, m_busy, m_done});
      end
      checks++;
      if (fall_strobe !== (det_q & ~O)) begin
        failures++;
        $display("FAIL abort_edge_det i=%0d got=%b want=%b", i, fall_strobe, det_q & ~O);
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      // Re-pulsed start at 3 must be ignored; reset lands in the 2nd pulse's high phase.
      start = (i == 0) || (i == 3) || (i == 11);
      reset = (i != 8);
      low_len = 8'd2; high_len = 8'd3; num_pulses = 4'd3;
      if (i == 3) begin
        low_len = 8'd7; high_len = 8'd7; num_pulses = 4'd1;
      end
      @(posedge clk); #1;
      checks++;
      if ({O, fall_strobe, busy, done} !== {m_o, m_fs, m_busy, m_done}) begin
        failures++;
        $display("FAIL reset_mid i=%0d got=%b want=%b", i, {O, fall_strobe, busy, done},
                 {m_o, m_fs, m_busy, m_done});
      end
      checks++;
      if (fall_strobe !== (det_q & ~O)) begin
        failures++;
        $display("FAIL reset_mid_edge_det i=%0d got=%b want=%b", i, fall_strobe, det_q & ~O);
      end
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = 1'b1;
      low_len = 8'd2; high_len = 8'd1; num_pulses = 4'd1;
      @(posedge clk); #1;
      checks++;
      if ({O, fall_strobe, busy, done} !== {m_o, m_fs, m_busy, m_done}) begin
        failures++;
        $display("FAIL back_to_back i=%0d got=%b want=%b", i, {O, fall_strobe, busy, done},
                 {m_o, m_fs, m_busy, m_done});
      end
      checks++;
      if (fall_strobe !== (det_q & ~O)) begin
        failures++;
        $display("FAIL b2b_edge_det i=%0d got=%b want=%b", i, fall_strobe, det_q & ~O);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      reset = ($urandom_range(0, 99) != 0);
      low_len = 8'($urandom_range(0, 4));
      high_len = 8'($urandom_range(0, 4));
      num_pulses = 4'($urandom_range(0, 3));
      @(posedge clk); #1;
      checks++;
      if ({O, fall_strobe, busy, done} !== {m_o, m_fs, m_busy, m_done}) begin
        failures++;
        $display("FAIL random i=%0d got=%b want=%b", i, {O, fall_strobe, busy, done},
                 {m_o, m_fs, m_busy, m_done});
      end
      checks++;
      if (fall_strobe !== (det_q & ~O)) begin
        failures++;
        $display("FAIL random_edge_det i=%0d got=%b want=%b", i, fall_strobe, det_q & ~O);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    repeat (7) @(negedge clk);
    test_basic();
    test_zero_len();
    test_zero_count();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    repeat (8) @(negedge clk);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
